// File: rtl/rv32im_pkg.sv
// Shared RV32M definitions for the EX-stage mul/div unit:
// FUNC3 op codes, FSM state encoding and default datapath width.
package rv32im_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// Ports: CLK/RESET, load (dividend/divisor), step, quo_nxt/rem_nxt (post-step), last.
module muldiv_div_core
  import rv32im_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   trial;
  logic            fit;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder and quotient bits enter at the LSB.
  always_comb begin
    trial   = {rem_q, quo_q[XLEN-1]};
    fit     = (trial >= {1'b0, dsr_q});
    rem_nxt = fit ? XLEN'(trial - {1'b0, dsr_q}) : trial[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], fit};
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= CW'(XLEN - 1);
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide engine for EX; BUSY stalls IF/ID and ID/EX.
// Ports: CLK, RESET, FLUSH, HOLD, START, FUNC3, OP1, OP2 -> BUSY, DONE, RESULT.
module ex_muldiv_unit
  import rv32im_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int MUL_LATENCY = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            HOLD,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [MCW-1:0]  mcnt_q;

  logic            busy, accept, div_load, div_step;
  logic            res_ld;
  logic [XLEN-1:0] res_d;

  logic            in_sgn, in_zero, in_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  logic            a_sx, b_sx, a_neg, b_neg;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0] mul_res, div_res;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic            div_last;

  // Decode of the incoming op, used only on the accept edge.
  always_comb begin
    in_sgn   = !FUNC3[0];
    in_zero  = (OP2 == '0);
    in_ovf   = in_sgn && (OP1 == SMIN) && (&OP2);
    mag_a    = (in_sgn && OP1[XLEN-1]) ? -OP1 : OP1;
    mag_b    = (in_sgn && OP2[XLEN-1]) ? -OP2 : OP2;
    spec_res = '0;
    unique case (1'b1)
      in_zero: spec_res = FUNC3[1] ? OP1 : '1;
      in_ovf:  spec_res = FUNC3[1] ? '0 : SMIN;
      default: spec_res = '0;
    endcase
  end

  // Multiply and sign fix-up work from the latched operands.
  always_comb begin
    a_sx    = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
    b_sx    = (f3_q == F3_MULH);
    a_ext   = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
    b_ext   = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
    a_neg   = !f3_q[0] && a_q[XLEN-1];
    b_neg   = !f3_q[0] && b_q[XLEN-1];
    if (f3_q[1])
      div_res = a_neg ? -rem_nxt : rem_nxt;
    else
      div_res = (a_neg ^ b_neg) ? -quo_nxt : quo_nxt;
  end

  muldiv_div_core #(
    .XLEN (XLEN)
  ) u_div (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt),
    .last     (div_last)
  );

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    accept   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    res_ld   = 1'b0;
    res_d    = RESULT;
    unique case (state_q)
      ST_IDLE: begin
        if (START && !FLUSH) begin
          busy = 1'b1;
          // A frozen pipeline defers acceptance until HOLD drops.
          if (!HOLD) begin
            accept = 1'b1;
            if (!FUNC3[2]) begin
              state_d = ST_MUL;
            end else if (in_zero || in_ovf) begin
              state_d = ST_DONE;
              res_ld  = 1'b1;
              res_d   = spec_res;
            end else begin
              state_d  = ST_DIV;
              div_load = 1'b1;
            end
          end
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (FLUSH) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == '0) begin
          state_d = ST_DONE;
          res_ld  = 1'b1;
          res_d   = mul_res;
        end
      end
      ST_DIV: begin
        busy = 1'b1;
        if (FLUSH) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) begin
            state_d = ST_DONE;
            res_ld  = 1'b1;
            res_d   = div_res;
          end
        end
      end
      ST_DONE: begin
        if (FLUSH || !HOLD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY = busy && !RESET;
  assign DONE = (state_q == ST_DONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcnt_q  <= '0;
      RESULT  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q   <= FUNC3;
        a_q    <= OP1;
        b_q    <= OP2;
        mcnt_q <= MCW'(MUL_LATENCY - 1);
      end else if (state_q == ST_MUL && mcnt_q != '0) begin
        mcnt_q <= mcnt_q - 1'b1;
      end
      if (res_ld) RESULT <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized bench for ex_muldiv_unit with an arithmetic reference model.
// Drives ops, flushes, holds and resets; checks BUSY/DONE/RESULT every cycle.
module tb_ex_muldiv_unit;
  import rv32im_pkg::*;

  localparam int XL = 32;
  localparam int ML = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic        HOLD = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  FUNC3 = '0;
  logic [31:0] OP1 = '0;
  logic [31:0] OP2 = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  ex_muldiv_unit #(
    .XLEN        (XL),
    .MUL_LATENCY (ML)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .FLUSH  (FLUSH),
    .HOLD   (HOLD),
    .START  (START),
    .FUNC3  (FUNC3),
    .OP1    (OP1),
    .OP2    (OP2),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_res = '0;
  logic [31:0] cur_res = '0;
  string       tag = "init";

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] x, y, p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      F3_MUL, F3_MULH: begin
        x = 64'(sa); y = 64'(sb);
      end
      F3_MULHSU: begin
        x = 64'(sa); y = {32'b0, b};
      end
      default: begin
        x = {32'b0, a}; y = {32'b0, b};
      end
    endcase
    p = x * y;
    if (!f[2]) return (f == F3_MUL) ? p[31:0] : p[63:32];
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'h0 : 32'h8000_0000;
    case (f)
      F3_DIV:  return 32'(sa / sb);
      F3_REM:  return 32'(sa % sb);
      F3_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int busy_n(input logic [2:0] f,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (!f[2]) return 1 + ML;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XL + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic expect_(input logic b, input logic d,
                         input logic [31:0] r, input string t);
    exp_busy = b;
    exp_done = d;
    exp_res  = r;
    tag      = t;
    chk_en   = 1'b1;
  endtask

  always @(negedge CLK) begin
    #2;
    if (chk_en) begin
      n_cmp++;
      if (BUSY !== exp_busy) begin
        n_bad++;
        $display("FAIL %s busy: got %b want %b t=%0t", tag, BUSY, exp_busy, $time);
      end
      n_cmp++;
      if (DONE !== exp_done) begin
        n_bad++;
        $display("FAIL %s done: got %b want %b t=%0t", tag, DONE, exp_done, $time);
      end
      n_cmp++;
      if (RESULT !== exp_res) begin
        n_bad++;
        $display("FAIL %s result: got %h want %h t=%0t", tag, RESULT, exp_res, $time);
      end
    end
  end

  // One op from acceptance to the advance edge. flush_at<0 means no flush.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input int hold_n, input int flush_at,
                        input bit mid_hold, input string t);
    int nb;
    nb = busy_n(f, a, b);
    for (int k = 0; k < nb; k++) begin
      @(negedge CLK);
      START = 1'b1;
      FUNC3 = f;
      OP1   = (k == 0) ? a : $urandom;
      OP2   = (k == 0) ? b : $urandom;
      FLUSH = (k == flush_at);
      HOLD  = (k > 0) && mid_hold && ($urandom_range(0, 1) == 1);
      expect_(!(k == 0 && k == flush_at), 1'b0, cur_res, t);
      if (k == flush_at) begin
        @(negedge CLK);
        START = 1'b0;
        FLUSH = 1'b0;
        HOLD  = 1'b0;
        expect_(1'b0, 1'b0, cur_res, {t, "_flushed"});
        return;
      end
    end
    cur_res = r;
    for (int k = 0; k <= hold_n; k++) begin
      @(negedge CLK);
      START = 1'b1;
      FLUSH = 1'b0;
      HOLD  = (k < hold_n);
      OP1   = $urandom;
      OP2   = $urandom;
      expect_(1'b0, 1'b1, cur_res, {t, "_done"});
    end
  endtask

  task automatic idle_cycle(input string t);
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    HOLD  = 1'b0;
    expect_(1'b0, 1'b0, cur_res, t);
  endtask

  logic [2:0]  df [12];
  logic [31:0] da [12];
  logic [31:0] db [12];
  logic [31:0] dr [12];

  initial begin
    df = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU,
           F3_DIV, F3_REM, F3_DIVU, F3_REMU,
           F3_DIV, F3_REM, F3_DIV, F3_REM};
    da = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
           32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    db = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
           32'd2, 32'd2, 32'd7, 32'd7,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dr = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
           32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    repeat (2) begin
      @(negedge CLK);
      START = 1'b1;
      expect_(1'b0, 1'b0, 32'h0, "reset");
    end
    @(negedge CLK);
    RESET = 1'b0;
    START = 1'b0;
    expect_(1'b0, 1'b0, 32'h0, "post_reset");

    for (int i = 0; i < 12; i++) begin
      run_op(df[i], da[i], db[i], dr[i], 0, -1, 1'b0,
             $sformatf("dir%0d", i));
      idle_cycle("dir_idle");
    end

    run_op(F3_MUL, 32'd6, 32'd9, 32'd54, 3, -1, 1'b0, "hold3");
    idle_cycle("hold3_idle");

    run_op(F3_DIVU, 32'd1000, 32'd3, 32'd333, 0, 10, 1'b0, "flush10");
    idle_cycle("flush_idle");
    run_op(F3_MUL, 32'd3, 32'd3, 32'd9, 0, 0, 1'b0, "flush_idle_start");

    run_op(F3_MUL, 32'd12, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 0, -1, 1'b0, "b2b_mul");
    run_op(F3_DIV, 32'd50, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 0, -1, 1'b1, "b2b_div");
    idle_cycle("b2b_idle");

    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      START = 1'b1;
      FUNC3 = F3_DIVU;
      OP1   = 32'd77;
      OP2   = 32'd5;
      expect_(1'b1, 1'b0, cur_res, "pre_reset_div");
    end
    @(negedge CLK);
    RESET = 1'b1;
    cur_res = 32'h0;
    expect_(1'b0, 1'b0, cur_res, "reset_mid_div");
    @(negedge CLK);
    RESET = 1'b0;
    START = 1'b0;
    expect_(1'b0, 1'b0, cur_res, "after_reset");

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          fl;
      f  = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      fl = ($urandom_range(0, 7) == 0)
         ? $urandom_range(0, busy_n(f, a, b) - 1) : -1;
      run_op(f, a, b, model(f, a, b), $urandom_range(0, 2), fl,
             $urandom_range(0, 1) == 1, $sformatf("rnd%0d_f%0d", i, f));
      if ($urandom_range(0, 1) == 1) idle_cycle("rnd_idle");
    end

    idle_cycle("final");
    @(negedge CLK);
    #4;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
